// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : MEM pipeline stage; word loads/stores over a req/ack memory
//               port with timeout, stall generation and MEM/WB registers.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] RS2data_i,
  input  logic [4:0]  RDaddr_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic [31:0] ALUResult_o,
  output logic [31:0] ReadData_o,
  output logic [4:0]  RDaddr_o,
  output logic        misalign_o,
  output logic        timeout_o
);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_BUSY = 1'b1;
  localparam logic [7:0] c_LAST_WAIT = 8'(TIMEOUT - 1);

  logic [0:0]  r_state;
  logic [0:0]  w_stateNext;
  logic [7:0]  r_waitCnt;
  logic        r_capRegWrite;
  logic        r_capMemtoReg;
  logic [31:0] r_capALUResult;
  logic [4:0]  r_capRDaddr;

  logic w_access;
  logic w_aligned;
  logic w_lastWait;
  logic w_pass;
  logic w_misalign;
  logic w_issue;
  logic w_complete;
  logic w_expire;
  logic w_stall;

  assign w_access   = MemRead_i | MemWrite_i;
  assign w_aligned  = (ALUResult_i[1:0] == 2'b00);
  assign w_lastWait = (r_waitCnt == c_LAST_WAIT);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= c_IDLE;
    else       r_state <= w_stateNext;
  end

  // Next-state logic
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      c_IDLE:  if (w_access && w_aligned) w_stateNext = c_BUSY;
      c_BUSY:  if (mem_ack_i || w_lastWait) w_stateNext = c_IDLE;
      default: w_stateNext = c_IDLE;
    endcase
  end

  // Output / control decode; an ack on the final wait cycle still completes
  always_comb begin
    w_pass     = 1'b0;
    w_misalign = 1'b0;
    w_issue    = 1'b0;
    w_complete = 1'b0;
    w_expire   = 1'b0;
    w_stall    = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (!w_access)       w_pass = 1'b1;
        else if (!w_aligned) w_misalign = 1'b1;
        else begin
          w_issue = 1'b1;
          w_stall = 1'b1;
        end
      end
      c_BUSY: begin
        if (mem_ack_i)       w_complete = 1'b1;
        else if (w_lastWait) w_expire = 1'b1;
        else                 w_stall = 1'b1;
      end
      default: ;
    endcase
    if (rst_i) w_stall = 1'b0;
  end

  assign stall_o = w_stall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_req_o      <= 1'b0;
      mem_we_o       <= 1'b0;
      mem_addr_o     <= 32'd0;
      mem_wdata_o    <= 32'd0;
      r_waitCnt      <= 8'd0;
      r_capRegWrite  <= 1'b0;
      r_capMemtoReg  <= 1'b0;
      r_capALUResult <= 32'd0;
      r_capRDaddr    <= 5'd0;
      RegWrite_o     <= 1'b0;
      MemtoReg_o     <= 1'b0;
      ALUResult_o    <= 32'd0;
      ReadData_o     <= 32'd0;
      RDaddr_o       <= 5'd0;
      misalign_o     <= 1'b0;
      timeout_o      <= 1'b0;
    end else begin
      misalign_o  <= w_misalign;
      timeout_o   <= w_expire;
      // MEM/WB defaults to a bubble unless something retires this cycle
      RegWrite_o  <= 1'b0;
      MemtoReg_o  <= 1'b0;
      ALUResult_o <= 32'd0;
      ReadData_o  <= 32'd0;
      RDaddr_o    <= 5'd0;

      if (w_pass) begin
        RegWrite_o  <= RegWrite_i;
        MemtoReg_o  <= MemtoReg_i;
        ALUResult_o <= ALUResult_i;
        RDaddr_o    <= RDaddr_i;
      end

      if (w_issue) begin
        r_capRegWrite  <= RegWrite_i;
        r_capMemtoReg  <= MemtoReg_i;
        r_capALUResult <= ALUResult_i;
        r_capRDaddr    <= RDaddr_i;
        mem_req_o      <= 1'b1;
        mem_we_o       <= MemWrite_i;
        mem_addr_o     <= ALUResult_i;
        mem_wdata_o    <= RS2data_i;
        r_waitCnt      <= 8'd0;
      end

      if (w_complete) begin
        RegWrite_o  <= r_capRegWrite;
        MemtoReg_o  <= r_capMemtoReg;
        ALUResult_o <= r_capALUResult;
        ReadData_o  <= mem_we_o ? 32'd0 : mem_rdata_i;
        RDaddr_o    <= r_capRDaddr;
        mem_req_o   <= 1'b0;
      end else if (w_expire) begin
        mem_req_o <= 1'b0;
      end else if (r_state == c_BUSY) begin
        r_waitCnt <= r_waitCnt + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Self-checking bench for mem_access_stage (transaction model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
  logic [31:0] ALUResult_i, RS2data_i;
  logic [4:0]  RDaddr_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
  logic        RegWrite_o, MemtoReg_o;
  logic [31:0] ALUResult_o, ReadData_o;
  logic [4:0]  RDaddr_o;
  logic        misalign_o, timeout_o;

  int passed = 0;
  int total  = 0;

  logic [70:0] wbObs;
  logic [65:0] memObs;
  assign wbObs  = {RegWrite_o, MemtoReg_o, ALUResult_o, ReadData_o, RDaddr_o};
  assign memObs = {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o};

  always #5 clk_i = ~clk_i;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .ALUResult_i(ALUResult_i), .RS2data_i(RS2data_i), .RDaddr_i(RDaddr_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
    .ALUResult_o(ALUResult_o), .ReadData_o(ReadData_o), .RDaddr_o(RDaddr_o),
    .misalign_o(misalign_o), .timeout_o(timeout_o)
  );

  task automatic drive_nop();
    RegWrite_i = 0; MemtoReg_i = 0; MemRead_i = 0; MemWrite_i = 0;
    ALUResult_i = 0; RS2data_i = 0; RDaddr_i = 0;
  endtask

  // ALU op: one-edge pass-through, no stall, no memory activity
  task automatic alu_op(input logic rw, input logic mtr, input logic [31:0] res, input logic [4:0] rd);
    logic [70:0] exp;
    RegWrite_i = rw; MemtoReg_i = mtr; MemRead_i = 0; MemWrite_i = 0;
    ALUResult_i = res; RS2data_i = $urandom; RDaddr_i = rd;
    exp = {rw, mtr, res, 32'd0, rd};
    #1;
    total++;
    if (stall_o !== 1'b0) $display("FAIL alu_stall: got %b expected 0", stall_o); else passed++;
    @(posedge clk_i); #1;
    total++;
    if (wbObs !== exp) $display("FAIL alu_wb: got %h expected %h", wbObs, exp); else passed++;
    total++;
    if ({mem_req_o, misalign_o, timeout_o} !== 3'b000)
      $display("FAIL alu_flags: got req/mis/to=%b expected 000", {mem_req_o, misalign_o, timeout_o});
    else passed++;
  endtask

  // Aligned access; lat = BUSY cycle carrying the ack (lat > TO means none)
  task automatic mem_op(input logic mr, input logic mw, input logic rw, input logic mtr,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                        input int lat, input logic [31:0] rdata);
    int stallCnt;
    int expStall;
    logic [65:0] expMem;
    logic [70:0] expWb;
    stallCnt = 0;
    expStall = (lat >= 1 && lat <= TO) ? lat : TO;
    expMem = {1'b1, mw, addr, wdata};
    RegWrite_i = rw; MemtoReg_i = mtr; MemRead_i = mr; MemWrite_i = mw;
    ALUResult_i = addr; RS2data_i = wdata; RDaddr_i = rd;
    #1;
    if (stall_o === 1'b1) stallCnt++;
    total++;
    if (stall_o !== 1'b1) $display("FAIL issue_stall: got %b expected 1", stall_o); else passed++;
    @(posedge clk_i); #1;
    total++;
    if (memObs !== expMem) $display("FAIL issue_mem: got %h expected %h", memObs, expMem); else passed++;
    total++;
    if (wbObs !== 71'd0) $display("FAIL issue_bubble: got %h expected 0", wbObs); else passed++;
    for (int k = 1; k <= TO; k++) begin
      // Frozen pipeline may present anything; none of it must be re-captured
      RegWrite_i = $urandom; MemtoReg_i = $urandom; MemRead_i = $urandom; MemWrite_i = $urandom;
      ALUResult_i = $urandom; RS2data_i = $urandom; RDaddr_i = $urandom;
      mem_rdata_i = (k == lat) ? rdata : $urandom;
      mem_ack_i = (k == lat);
      #1;
      if (stall_o === 1'b1) stallCnt++;
      @(posedge clk_i); #1;
      mem_ack_i = 0;
      if (k == lat) begin
        expWb = {rw, mtr, addr, (mw ? 32'd0 : rdata), rd};
        total++;
        if (wbObs !== expWb) $display("FAIL done_wb: got %h expected %h", wbObs, expWb); else passed++;
        total++;
        if ({mem_req_o, timeout_o} !== 2'b00)
          $display("FAIL done_req: got req/to=%b expected 00", {mem_req_o, timeout_o});
        else passed++;
        break;
      end else if (k == TO) begin
        total++;
        if ({mem_req_o, timeout_o, wbObs} !== {2'b01, 71'd0})
          $display("FAIL timeout: got req=%b to=%b wb=%h expected req=0 to=1 wb=0",
                   mem_req_o, timeout_o, wbObs);
        else passed++;
      end else begin
        total++;
        if ({memObs, timeout_o, wbObs} !== {expMem, 1'b0, 71'd0})
          $display("FAIL wait_hold: got mem=%h to=%b wb=%h expected mem=%h to=0 wb=0",
                   memObs, timeout_o, wbObs, expMem);
        else passed++;
      end
    end
    total++;
    if (stallCnt != expStall) $display("FAIL stall_cycles: got %0d expected %0d", stallCnt, expStall);
    else passed++;
  endtask

  task automatic misaligned_op(input logic mr, input logic mw, input logic [31:0] addr);
    RegWrite_i = 1; MemtoReg_i = mr; MemRead_i = mr; MemWrite_i = mw;
    ALUResult_i = addr; RS2data_i = $urandom; RDaddr_i = 5'd7;
    #1;
    total++;
    if (stall_o !== 1'b0) $display("FAIL mis_stall: got %b expected 0", stall_o); else passed++;
    @(posedge clk_i); #1;
    total++;
    if ({misalign_o, mem_req_o, wbObs} !== {2'b10, 71'd0})
      $display("FAIL mis_pulse: got mis=%b req=%b wb=%h expected mis=1 req=0 wb=0",
               misalign_o, mem_req_o, wbObs);
    else passed++;
  endtask

  task automatic test_reset();
    rst_i = 1; mem_ack_i = 0; mem_rdata_i = 0;
    drive_nop();
    MemRead_i = 1; ALUResult_i = 32'h40;
    #12;
    total++;
    if ({stall_o, memObs, wbObs, misalign_o, timeout_o} !== '0)
      $display("FAIL reset_state: got stall=%b mem=%h wb=%h expected all 0", stall_o, memObs, wbObs);
    else passed++;
    drive_nop();
    @(negedge clk_i); rst_i = 0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_alu();
    alu_op(1'b1, 1'b0, 32'h0000_0010, 5'd5);
    for (int i = 0; i < 4; i++) alu_op($urandom, $urandom, $urandom, $urandom);
  endtask

  task automatic test_load_wait();
    mem_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'hAAAA_5555, 5'd9, 3, 32'hDEAD_BEEF);
  endtask

  task automatic test_store();
    mem_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h1234_5678, 5'd0, 1, 32'hFFFF_FFFF);
  endtask

  task automatic test_misalign();
    misaligned_op(1'b1, 1'b0, 32'h102);
    alu_op(1'b1, 1'b0, 32'h55, 5'd3);
  endtask

  task automatic test_timeout();
    mem_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 32'd0, 5'd4, TO + 1, 32'd0);
    mem_ack_i = 1; mem_rdata_i = 32'hBAD0_BAD0;
    alu_op(1'b1, 1'b0, 32'h77, 5'd8);
    mem_ack_i = 0;
  endtask

  task automatic test_reset_busy();
    RegWrite_i = 1; MemtoReg_i = 1; MemRead_i = 1; MemWrite_i = 0;
    ALUResult_i = 32'h400; RS2data_i = 0; RDaddr_i = 5'd2;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 1;
    #1;
    total++;
    if ({stall_o, memObs, wbObs, misalign_o, timeout_o} !== '0)
      $display("FAIL reset_busy: got stall=%b mem=%h wb=%h expected all 0", stall_o, memObs, wbObs);
    else passed++;
    drive_nop();
    mem_ack_i = 1; mem_rdata_i = 32'h1111_2222;
    @(posedge clk_i); #1;
    mem_ack_i = 0;
    @(negedge clk_i); rst_i = 0;
    mem_ack_i = 1;
    @(posedge clk_i); #1;
    mem_ack_i = 0;
    total++;
    if ({stall_o, mem_req_o, wbObs} !== '0)
      $display("FAIL post_reset_ack: got stall=%b req=%b wb=%h expected all 0", stall_o, mem_req_o, wbObs);
    else passed++;
    alu_op(1'b1, 1'b0, 32'hCAFE_0000, 5'd31);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      int kind;
      logic mr, mw;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      a = $urandom & 32'hFFFF_FFFC;
      case (kind)
        0: alu_op($urandom, $urandom, $urandom, $urandom);
        1, 2: begin
          mw = $urandom; mr = mw ? 1'($urandom) : 1'b1;
          mem_op(mr, mw, $urandom, $urandom, a, $urandom, $urandom,
                 $urandom_range(1, TO + 1), $urandom);
        end
        default: misaligned_op($urandom, 1'b1, a | 32'($urandom_range(1, 3)));
      endcase
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_store();
    test_misalign();
    test_timeout();
    test_reset_busy();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
